// File: rtl/io_hub.sv
// io_hub: fans the CPU's single input/output handshake pair out to per-channel FIFOs.
// A select register picks which input and output channel the CPU currently talks to.
module io_hub #(
  parameter int DATA_W = 16,
  parameter int IN_CH  = 2,
  parameter int OUT_CH = 2,
  parameter int DEPTH  = 4,
  localparam int ISW = (IN_CH > 1) ? $clog2(IN_CH) : 1,
  localparam int OSW = (OUT_CH > 1) ? $clog2(OUT_CH) : 1,
  localparam int CW  = $clog2(DEPTH) + 1
) (
  input  logic                     clk,
  input  logic                     rst_b,
  input  logic                     sel_we,
  input  logic [ISW-1:0]           sel_in,
  input  logic [OSW-1:0]           sel_out,
  input  logic                     inp_req,
  output logic                     inp_ack,
  output logic [DATA_W-1:0]        inp_data,
  input  logic                     out_req,
  input  logic [DATA_W-1:0]        out_data,
  output logic                     out_ack,
  input  logic [IN_CH-1:0]         ch_in_valid,
  input  logic [IN_CH*DATA_W-1:0]  ch_in_data,
  output logic [IN_CH-1:0]         ch_in_ready,
  output logic [OUT_CH-1:0]        ch_out_valid,
  output logic [OUT_CH*DATA_W-1:0] ch_out_data,
  input  logic [OUT_CH-1:0]        ch_out_ready,
  output logic [IN_CH-1:0]         in_avail,
  output logic [OUT_CH-1:0]        out_full
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0]  FULL_CNT = CW'(DEPTH);
  localparam logic [ISW:0]   IN_LIM   = (ISW+1)'(IN_CH);
  localparam logic [OSW:0]   OUT_LIM  = (OSW+1)'(OUT_CH);

  typedef enum logic [1:0] {IN_IDLE, IN_ACK, IN_WAIT} in_state_t;
  typedef enum logic [1:0] {OUT_IDLE, OUT_ACK, OUT_WAIT} out_state_t;

  in_state_t  in_state;
  out_state_t out_state;

  logic [ISW-1:0] sel_in_q;
  logic [OSW-1:0] sel_out_q;

  logic [IN_CH-1:0]              in_pop;
  logic [IN_CH-1:0][DATA_W-1:0]  in_head;
  logic [OUT_CH-1:0]             out_push;

  logic              in_sel_avail;
  logic [DATA_W-1:0] in_sel_head;
  logic              out_sel_full;
  logic              in_accept;
  logic              out_accept;

  // Out-of-range indices are dropped per field so a bad write cannot strand the CPU.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      sel_in_q  <= '0;
      sel_out_q <= '0;
    end else if (sel_we) begin
      if ({1'b0, sel_in} < IN_LIM)
        sel_in_q <= sel_in;
      if ({1'b0, sel_out} < OUT_LIM)
        sel_out_q <= sel_out;
    end
  end

  for (genvar i = 0; i < IN_CH; i++) begin : g_in_fifo
    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    logic              push;

    assign push           = ch_in_valid[i] && ch_in_ready[i];
    assign ch_in_ready[i] = (count != FULL_CNT);
    assign in_avail[i]    = (count != '0);
    assign in_head[i]     = mem[rd_ptr];
    assign in_pop[i]      = in_accept && (sel_in_q == ISW'(i));

    always_ff @(posedge clk) begin
      if (push)
        mem[wr_ptr] <= ch_in_data[i*DATA_W +: DATA_W];
    end

    always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push)
          wr_ptr <= wr_ptr + 1'b1;
        if (in_pop[i])
          rd_ptr <= rd_ptr + 1'b1;
        case ({push, in_pop[i]})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: ;
        endcase
      end
    end
  end

  for (genvar i = 0; i < OUT_CH; i++) begin : g_out_fifo
    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    logic              pop;

    assign pop                            = ch_out_valid[i] && ch_out_ready[i];
    assign ch_out_valid[i]                = (count != '0);
    assign out_full[i]                    = (count == FULL_CNT);
    assign ch_out_data[i*DATA_W +: DATA_W] = mem[rd_ptr];
    assign out_push[i]                    = out_accept && (sel_out_q == OSW'(i));

    always_ff @(posedge clk) begin
      if (out_push[i])
        mem[wr_ptr] <= out_data;
    end

    always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (out_push[i])
          wr_ptr <= wr_ptr + 1'b1;
        if (pop)
          rd_ptr <= rd_ptr + 1'b1;
        case ({out_push[i], pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    in_sel_avail = 1'b0;
    in_sel_head  = '0;
    for (int i = 0; i < IN_CH; i++) begin
      if (sel_in_q == ISW'(i)) begin
        in_sel_avail = in_avail[i];
        in_sel_head  = in_head[i];
      end
    end
  end

  always_comb begin
    out_sel_full = 1'b0;
    for (int i = 0; i < OUT_CH; i++) begin
      if (sel_out_q == OSW'(i))
        out_sel_full = out_full[i];
    end
  end

  assign in_accept  = (in_state == IN_IDLE) && inp_req && in_sel_avail;
  assign out_accept = (out_state == OUT_IDLE) && out_req && !out_sel_full;

  // The WAIT state forces the CPU to drop its request before a second word is served.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      in_state <= IN_IDLE;
      inp_ack  <= 1'b0;
      inp_data <= '0;
    end else begin
      inp_ack <= 1'b0;
      case (in_state)
        IN_IDLE: begin
          if (in_accept) begin
            inp_data <= in_sel_head;
            inp_ack  <= 1'b1;
            in_state <= IN_ACK;
          end
        end
        IN_ACK:  in_state <= IN_WAIT;
        IN_WAIT: if (!inp_req) in_state <= IN_IDLE;
        default: in_state <= IN_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      out_state <= OUT_IDLE;
      out_ack   <= 1'b0;
    end else begin
      out_ack <= 1'b0;
      case (out_state)
        OUT_IDLE: begin
          if (out_accept) begin
            out_ack   <= 1'b1;
            out_state <= OUT_ACK;
          end
        end
        OUT_ACK:  out_state <= OUT_WAIT;
        OUT_WAIT: if (!out_req) out_state <= OUT_IDLE;
        default:  out_state <= OUT_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_io_hub.sv
// Self-checking bench for io_hub: directed table, hand-written corner sequences and a
// randomized run, all shadowed by a queue-based model of the channel FIFOs and handshakes.
module tb_io_hub;
  localparam int DW  = 16;
  localparam int NI  = 3;
  localparam int NO  = 3;
  localparam int D   = 4;
  localparam int ISW = 2;
  localparam int OSW = 2;

  logic             clk = 1'b0;
  logic             rst_b;
  logic             sel_we;
  logic [ISW-1:0]   sel_in;
  logic [OSW-1:0]   sel_out;
  logic             inp_req;
  logic             inp_ack;
  logic [DW-1:0]    inp_data;
  logic             out_req;
  logic [DW-1:0]    out_data;
  logic             out_ack;
  logic [NI-1:0]    ch_in_valid;
  logic [NI*DW-1:0] ch_in_data;
  logic [NI-1:0]    ch_in_ready;
  logic [NO-1:0]    ch_out_valid;
  logic [NO*DW-1:0] ch_out_data;
  logic [NO-1:0]    ch_out_ready;
  logic [NI-1:0]    in_avail;
  logic [NO-1:0]    out_full;

  int n_cmp  = 0;
  int n_fail = 0;

  io_hub #(.DATA_W(DW), .IN_CH(NI), .OUT_CH(NO), .DEPTH(D)) dut (
    .clk(clk), .rst_b(rst_b), .sel_we(sel_we), .sel_in(sel_in), .sel_out(sel_out),
    .inp_req(inp_req), .inp_ack(inp_ack), .inp_data(inp_data),
    .out_req(out_req), .out_data(out_data), .out_ack(out_ack),
    .ch_in_valid(ch_in_valid), .ch_in_data(ch_in_data), .ch_in_ready(ch_in_ready),
    .ch_out_valid(ch_out_valid), .ch_out_data(ch_out_data), .ch_out_ready(ch_out_ready),
    .in_avail(in_avail), .out_full(out_full)
  );

  always #5 clk = ~clk;

  // Reference model: one queue per channel plus "must drop request first" flags.
  logic [DW-1:0] iq [NI][$];
  logic [DW-1:0] oq [NO][$];
  int            m_sel_in, m_sel_out;
  bit            m_iblk, m_ijust, m_oblk, m_ojust;
  logic          m_exp_iack, m_exp_oack;
  logic [DW-1:0] m_exp_idata;
  bit            rec_on;
  logic [DW-1:0] drained [$];

  typedef struct {
    logic [NI-1:0]  valid;
    logic [DW-1:0]  data;
    logic           req;
    logic           we;
    logic [ISW-1:0] sel;
    logic           exp_ack;
    logic [DW-1:0]  exp_data;
    logic [NI-1:0]  exp_avail;
  } vec_t;
  vec_t tbl [18];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic resetModel();
    for (int i = 0; i < NI; i++) iq[i].delete();
    for (int i = 0; i < NO; i++) oq[i].delete();
    m_sel_in = 0; m_sel_out = 0;
    m_iblk = 0; m_ijust = 0; m_oblk = 0; m_ojust = 0;
    m_exp_iack = 0; m_exp_oack = 0; m_exp_idata = '0;
  endtask

  task automatic checkModel();
    logic [NI-1:0] e_rdy, e_av;
    logic [NO-1:0] e_val, e_full;
    for (int i = 0; i < NI; i++) begin
      e_rdy[i] = (iq[i].size() < D);
      e_av[i]  = (iq[i].size() != 0);
    end
    for (int o = 0; o < NO; o++) begin
      e_val[o]  = (oq[o].size() != 0);
      e_full[o] = (oq[o].size() == D);
      if (oq[o].size() != 0)
        checkOutput("model ch_out_data", ch_out_data[o*DW +: DW], oq[o][0]);
    end
    checkOutput("model ch_in_ready", ch_in_ready, e_rdy);
    checkOutput("model in_avail", in_avail, e_av);
    checkOutput("model ch_out_valid", ch_out_valid, e_val);
    checkOutput("model out_full", out_full, e_full);
    checkOutput("model inp_ack", inp_ack, m_exp_iack);
    checkOutput("model inp_data", inp_data, m_exp_idata);
    checkOutput("model out_ack", out_ack, m_exp_oack);
  endtask

  // Advance the model across one clock edge using the inputs currently driven.
  task automatic updateModel();
    bit            iacc, oacc;
    bit            ipush [NI];
    bit            opop [NO];
    logic [DW-1:0] junk;
    iacc = !m_iblk && inp_req && (iq[m_sel_in].size() > 0);
    oacc = !m_oblk && out_req && (oq[m_sel_out].size() < D);
    for (int i = 0; i < NI; i++) ipush[i] = ch_in_valid[i] && (iq[i].size() < D);
    for (int o = 0; o < NO; o++) opop[o] = ch_out_ready[o] && (oq[o].size() > 0);
    if (rec_on && ch_out_valid[0] && ch_out_ready[0]) drained.push_back(ch_out_data[DW-1:0]);

    if (iacc) m_exp_idata = iq[m_sel_in].pop_front();
    for (int i = 0; i < NI; i++) if (ipush[i]) iq[i].push_back(ch_in_data[i*DW +: DW]);
    for (int o = 0; o < NO; o++) if (opop[o]) junk = oq[o].pop_front();
    if (oacc) oq[m_sel_out].push_back(out_data);
    m_exp_iack = iacc;
    m_exp_oack = oacc;

    if (iacc) begin m_iblk = 1; m_ijust = 1; end
    else begin
      if (m_iblk && !m_ijust && !inp_req) m_iblk = 0;
      m_ijust = 0;
    end
    if (oacc) begin m_oblk = 1; m_ojust = 1; end
    else begin
      if (m_oblk && !m_ojust && !out_req) m_oblk = 0;
      m_ojust = 0;
    end

    if (sel_we) begin
      if (int'(sel_in) < NI)  m_sel_in  = int'(sel_in);
      if (int'(sel_out) < NO) m_sel_out = int'(sel_out);
    end
  endtask

  task automatic applyStimulus();
    checkModel();
    if (rst_b) updateModel();
    else resetModel();
    @(posedge clk);
    #1;
  endtask

  task automatic cpuRead(input logic [DW-1:0] exp);
    bit got = 0;
    inp_req = 1'b1;
    for (int k = 0; k < 8 && !got; k++) begin
      applyStimulus();
      got = inp_ack;
    end
    checkOutput("read ack seen", got, 1'b1);
    checkOutput("read data", inp_data, exp);
    inp_req = 1'b0;
    applyStimulus();
    applyStimulus();
  endtask

  task automatic cpuWrite(input logic [DW-1:0] v);
    bit got = 0;
    out_req  = 1'b1;
    out_data = v;
    for (int k = 0; k < 8 && !got; k++) begin
      applyStimulus();
      got = out_ack;
    end
    checkOutput("write ack seen", got, 1'b1);
    out_req = 1'b0;
    applyStimulus();
    applyStimulus();
  endtask

  task automatic selectChannels(input logic [ISW-1:0] si, input logic [OSW-1:0] so);
    sel_we = 1'b1; sel_in = si; sel_out = so;
    applyStimulus();
    sel_we = 1'b0;
  endtask

  initial begin
    bit got;
    tbl[0]  = '{3'b010, 16'hBEEF, 1'b0, 1'b1, 2'd1, 1'b0, 16'h0000, 3'b010};
    tbl[1]  = '{3'b000, 16'h0000, 1'b1, 1'b0, 2'd0, 1'b1, 16'hBEEF, 3'b000};
    tbl[2]  = '{3'b000, 16'h0000, 1'b1, 1'b0, 2'd0, 1'b0, 16'hBEEF, 3'b000};
    tbl[3]  = '{3'b010, 16'h1111, 1'b1, 1'b0, 2'd0, 1'b0, 16'hBEEF, 3'b010};
    tbl[4]  = '{3'b000, 16'h0000, 1'b1, 1'b0, 2'd0, 1'b0, 16'hBEEF, 3'b010};
    tbl[5]  = '{3'b000, 16'h0000, 1'b0, 1'b0, 2'd0, 1'b0, 16'hBEEF, 3'b010};
    tbl[6]  = '{3'b000, 16'h0000, 1'b1, 1'b0, 2'd0, 1'b1, 16'h1111, 3'b000};
    tbl[7]  = '{3'b000, 16'h0000, 1'b0, 1'b0, 2'd0, 1'b0, 16'h1111, 3'b000};
    tbl[8]  = '{3'b000, 16'h0000, 1'b0, 1'b0, 2'd0, 1'b0, 16'h1111, 3'b000};
    tbl[9]  = '{3'b001, 16'h2222, 1'b0, 1'b1, 2'd3, 1'b0, 16'h1111, 3'b001};
    tbl[10] = '{3'b000, 16'h0000, 1'b1, 1'b0, 2'd0, 1'b0, 16'h1111, 3'b001};
    tbl[11] = '{3'b010, 16'h3333, 1'b1, 1'b0, 2'd0, 1'b0, 16'h1111, 3'b011};
    tbl[12] = '{3'b000, 16'h0000, 1'b1, 1'b0, 2'd0, 1'b1, 16'h3333, 3'b001};
    tbl[13] = '{3'b000, 16'h0000, 1'b0, 1'b0, 2'd0, 1'b0, 16'h3333, 3'b001};
    tbl[14] = '{3'b000, 16'h0000, 1'b0, 1'b1, 2'd0, 1'b0, 16'h3333, 3'b001};
    tbl[15] = '{3'b000, 16'h0000, 1'b1, 1'b0, 2'd0, 1'b1, 16'h2222, 3'b000};
    tbl[16] = '{3'b000, 16'h0000, 1'b0, 1'b0, 2'd0, 1'b0, 16'h2222, 3'b000};
    tbl[17] = '{3'b000, 16'h0000, 1'b0, 1'b0, 2'd0, 1'b0, 16'h2222, 3'b000};

    rst_b = 1'b0; sel_we = 0; sel_in = '0; sel_out = '0;
    inp_req = 0; out_req = 0; out_data = '0;
    ch_in_valid = '0; ch_in_data = '0; ch_out_ready = '1;
    rec_on = 0;
    resetModel();
    @(posedge clk); #1;
    checkOutput("reset ch_in_ready", ch_in_ready, 3'b111);
    checkOutput("reset ch_out_valid", ch_out_valid, 3'b000);
    checkOutput("reset in_avail", in_avail, 3'b000);
    checkOutput("reset out_full", out_full, 3'b000);
    checkOutput("reset inp_ack", inp_ack, 1'b0);
    checkOutput("reset out_ack", out_ack, 1'b0);
    checkOutput("reset inp_data", inp_data, 16'h0000);
    applyStimulus();
    rst_b = 1'b1;
    applyStimulus();

    $display("[TB] directed input table");
    for (int k = 0; k < 18; k++) begin
      ch_in_valid = tbl[k].valid;
      ch_in_data  = {NI{tbl[k].data}};
      inp_req     = tbl[k].req;
      sel_we      = tbl[k].we;
      sel_in      = tbl[k].sel;
      applyStimulus();
      checkOutput($sformatf("tbl[%0d] inp_ack", k), inp_ack, tbl[k].exp_ack);
      checkOutput($sformatf("tbl[%0d] inp_data", k), inp_data, tbl[k].exp_data);
      checkOutput($sformatf("tbl[%0d] in_avail", k), in_avail, tbl[k].exp_avail);
    end
    ch_in_valid = '0; inp_req = 0; sel_we = 0; sel_in = '0;

    $display("[TB] stalled request then late data");
    selectChannels(2'd2, 2'd0);
    inp_req = 1'b1;
    for (int k = 0; k < 10; k++) begin
      applyStimulus();
      checkOutput("stall inp_ack", inp_ack, 1'b0);
    end
    ch_in_valid = 3'b100; ch_in_data = {NI{16'h1234}};
    applyStimulus();
    ch_in_valid = '0;
    checkOutput("late data edge e ack", inp_ack, 1'b0);
    applyStimulus();
    checkOutput("late data edge e+1 ack", inp_ack, 1'b1);
    checkOutput("late data value", inp_data, 16'h1234);
    inp_req = 1'b0;
    applyStimulus(); applyStimulus();

    $display("[TB] output channel fill, stall and drain");
    ch_out_ready = 3'b110;
    selectChannels(2'd2, 2'd0);
    selectChannels(2'd2, 2'd3);
    for (int v = 1; v <= 4; v++) cpuWrite(DW'(v));
    checkOutput("out_full[0] after 4", out_full[0], 1'b1);
    checkOutput("ch_out_data[0] head", ch_out_data[DW-1:0], 16'h0001);
    out_req = 1'b1; out_data = 16'h0005;
    for (int k = 0; k < 6; k++) begin
      applyStimulus();
      checkOutput("full stall out_ack", out_ack, 1'b0);
    end
    rec_on = 1;
    ch_out_ready[0] = 1'b1;
    got = 0;
    for (int k = 0; k < 8 && !got; k++) begin
      applyStimulus();
      got = out_ack;
    end
    checkOutput("5th write acked after drain", got, 1'b1);
    out_req = 1'b0;
    for (int k = 0; k < 8; k++) applyStimulus();
    rec_on = 0;
    checkOutput("drained count", drained.size(), 5);
    for (int k = 0; k < 5 && k < drained.size(); k++)
      checkOutput($sformatf("drain order %0d", k), drained[k], DW'(k + 1));
    ch_out_ready = '1;

    $display("[TB] input FIFO full, simultaneous push/pop, wrap");
    selectChannels(2'd0, 2'd0);
    for (int k = 0; k < 4; k++) begin
      ch_in_valid = 3'b001; ch_in_data = {NI{DW'(16'hA000 + k)}};
      applyStimulus();
    end
    ch_in_valid = '0;
    checkOutput("ch_in_ready[0] full", ch_in_ready[0], 1'b0);
    checkOutput("in_avail[0] full", in_avail[0], 1'b1);
    cpuRead(16'hA000);
    ch_in_valid = 3'b001; ch_in_data = {NI{16'hA004}}; inp_req = 1'b1;
    applyStimulus();
    ch_in_valid = '0;
    checkOutput("simul pop ack", inp_ack, 1'b1);
    checkOutput("simul pop data", inp_data, 16'hA001);
    checkOutput("simul count kept (ready)", ch_in_ready[0], 1'b1);
    inp_req = 1'b0;
    applyStimulus(); applyStimulus();
    ch_in_valid = 3'b001; ch_in_data = {NI{16'hA005}};
    applyStimulus();
    ch_in_valid = '0;
    checkOutput("ch_in_ready[0] refull", ch_in_ready[0], 1'b0);
    for (int k = 2; k <= 5; k++) cpuRead(DW'(16'hA000 + k));
    checkOutput("in_avail[0] drained", in_avail[0], 1'b0);

    $display("[TB] select change on acceptance edge");
    ch_in_valid = 3'b011; ch_in_data = {16'h0000, 16'hC1C1, 16'hC0C0};
    applyStimulus();
    ch_in_valid = '0;
    inp_req = 1'b1; sel_we = 1'b1; sel_in = 2'd1;
    applyStimulus();
    sel_we = 1'b0;
    checkOutput("sel switch ack", inp_ack, 1'b1);
    checkOutput("sel switch old channel", inp_data, 16'hC0C0);
    inp_req = 1'b0;
    applyStimulus(); applyStimulus();
    cpuRead(16'hC1C1);

    $display("[TB] reset during ack with partially full FIFOs");
    for (int k = 0; k < 2; k++) begin
      ch_in_valid = 3'b010; ch_in_data = {NI{DW'(16'hD000 + k)}};
      applyStimulus();
    end
    ch_in_valid = '0;
    ch_out_ready = '0;
    cpuWrite(16'hE000);
    inp_req = 1'b1;
    applyStimulus();
    checkOutput("pre-reset inp_ack", inp_ack, 1'b1);
    #2 rst_b = 1'b0;
    #1;
    inp_req = 1'b0;
    resetModel();
    checkOutput("async reset inp_ack", inp_ack, 1'b0);
    checkOutput("async reset inp_data", inp_data, 16'h0000);
    checkOutput("async reset ch_in_ready", ch_in_ready, 3'b111);
    checkOutput("async reset ch_out_valid", ch_out_valid, 3'b000);
    checkOutput("async reset in_avail", in_avail, 3'b000);
    checkOutput("async reset out_full", out_full, 3'b000);
    applyStimulus(); applyStimulus();
    rst_b = 1'b1;
    ch_out_ready = '1;
    applyStimulus(); applyStimulus();
    checkOutput("post-reset in_avail", in_avail, 3'b000);
    checkOutput("post-reset ch_out_valid", ch_out_valid, 3'b000);
    ch_in_valid = 3'b001; ch_in_data = {NI{16'hF00D}};
    applyStimulus();
    ch_in_valid = '0;
    cpuRead(16'hF00D);

    $display("[TB] randomized traffic");
    for (int c = 0; c < 3000; c++) begin
      ch_in_valid = NI'($urandom_range(0, 7));
      for (int i = 0; i < NI; i++) ch_in_data[i*DW +: DW] = DW'($urandom);
      ch_out_ready = NO'($urandom_range(0, 7));
      inp_req  = ($urandom_range(0, 3) != 0);
      out_req  = ($urandom_range(0, 3) != 0);
      out_data = DW'($urandom);
      sel_we   = ($urandom_range(0, 15) == 0);
      sel_in   = ISW'($urandom_range(0, 3));
      sel_out  = OSW'($urandom_range(0, 3));
      applyStimulus();
    end
    sel_we = 0; inp_req = 0; out_req = 0; ch_in_valid = '0;
    applyStimulus();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
